// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl - write-side sequencer and buffer-swap controller for a
// double-buffered framebuffer.
//
// The renderer streams pixels over a valid/ready handshake. Each accepted pixel
// is written into the back buffer one cycle later. When the last pixel of a
// frame is accepted, the stream is stalled. On the next display vsync the
// controller toggles `selection`, so the completed frame becomes the front
// buffer without tearing.
//
// Bank polarity: selection=1 -> display reads bank 1 and writes go to bank 2.
//                selection=0 -> display reads bank 2 and writes go to bank 1.
//
// Optional feature (macro FB_SWAP_STATS_EN):
//   When defined, two saturating 16-bit statistics counters are added:
//   repeat_cnt (vsyncs that repeat the current front frame) and
//   resync_cnt (start-of-frame markers that arrive mid-frame).
//
// Ports:
//   clk          single clock for this block and the framebuffer write port
//   rst          synchronous, active-high reset
//   s_data       pixel from renderer
//   s_valid      s_data valid
//   s_sof        start-of-frame marker, qualified by s_valid
//   s_ready      block accepts a beat this cycle (combinational from state/rst)
//   vsync_pulse  one-cycle display frame boundary, synchronous to clk
//   wdata        framebuffer write data
//   waddr        framebuffer write address
//   we           framebuffer write enable
//   selection    framebuffer bank select
//   swap_pulse   one-cycle pulse coinciding with the first cycle of new selection
//   frame_ready  back buffer complete, awaiting vsync
//   repeat_cnt   (FB_SWAP_STATS_EN only) vsyncs seen while writing
//   resync_cnt   (FB_SWAP_STATS_EN only) mid-frame start-of-frame resyncs

module fb_swap_ctrl #(
    parameter int DATA_WIDTH   = 20,
    parameter int ADDR_WIDTH   = 14,
    parameter int FRAME_PIXELS = 16384
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_sof,
    output logic                  s_ready,
    input  logic                  vsync_pulse,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  we,
    output logic                  selection,
    output logic                  swap_pulse,
    output logic                  frame_ready
`ifdef FB_SWAP_STATS_EN
    ,
    output logic [15:0]           repeat_cnt,
    output logic [15:0]           resync_cnt
`endif
);

    localparam logic [0:0] ST_WRITE     = 1'b0;
    localparam logic [0:0] ST_WAIT_SWAP = 1'b1;

    // One extra bit so FRAME_PIXELS == 2**ADDR_WIDTH cannot wrap the compare.
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(FRAME_PIXELS - 1);

    logic [0:0]            state_q,      state_d;
    logic [ADDR_WIDTH-1:0] wr_cnt_q,     wr_cnt_d;
    logic                  selection_q,  selection_d;
    logic                  swap_pulse_q, swap_pulse_d;
    logic                  we_q,         we_d;
    logic [ADDR_WIDTH-1:0] waddr_q,      waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;

    logic                  accept_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic                  last_s;
    logic                  resync_s;

    // Handshake and address selection. A start-of-frame marker always restarts
    // the frame at address 0, whatever the counter holds.
    always_comb begin
        s_ready  = (state_q == ST_WRITE) & ~rst;
        accept_s = s_valid & s_ready;
        if (s_sof) begin
            addr_s = '0;
        end else begin
            addr_s = wr_cnt_q;
        end
        last_s   = ({1'b0, addr_s} == LAST_ADDR);
        resync_s = accept_s & s_sof & (wr_cnt_q != '0);
    end

    // Next-state logic for the frame sequencer, write port and bank select.
    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        selection_d  = selection_q;
        swap_pulse_d = 1'b0;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        case (state_q)
            ST_WRITE: begin
                // vsync is deliberately ignored here: the display simply
                // repeats the current front frame.
                if (accept_s) begin
                    we_d    = 1'b1;
                    waddr_d = addr_s;
                    wdata_d = s_data;
                    if (last_s) begin
                        wr_cnt_d = '0;
                        state_d  = ST_WAIT_SWAP;
                    end else begin
                        wr_cnt_d = addr_s + ADDR_WIDTH'(1);
                    end
                end else begin
                    we_d = 1'b0;
                end
            end
            ST_WAIT_SWAP: begin
                // The final pixel's write was registered on the edge that
                // entered this state. Any toggle therefore lands no earlier
                // than the edge after it, so that write stays in the old bank.
                if (vsync_pulse) begin
                    selection_d  = ~selection_q;
                    swap_pulse_d = 1'b1;
                    state_d      = ST_WRITE;
                    wr_cnt_d     = '0;
                end else begin
                    state_d = ST_WAIT_SWAP;
                end
            end
            default: begin
                state_d  = ST_WRITE;
                wr_cnt_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_WRITE;
            wr_cnt_q     <= '0;
            selection_q  <= 1'b0;
            swap_pulse_q <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            selection_q  <= selection_d;
            swap_pulse_q <= swap_pulse_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign wdata       = wdata_q;
    assign waddr       = waddr_q;
    assign we          = we_q;
    assign selection   = selection_q;
    assign swap_pulse  = swap_pulse_q;
    assign frame_ready = (state_q == ST_WAIT_SWAP);

`ifdef FB_SWAP_STATS_EN
    logic [15:0] repeat_cnt_q, repeat_cnt_d;
    logic [15:0] resync_cnt_q, resync_cnt_d;

    // Saturating statistics counters.
    always_comb begin
        repeat_cnt_d = repeat_cnt_q;
        resync_cnt_d = resync_cnt_q;
        if (vsync_pulse && (state_q == ST_WRITE) && (repeat_cnt_q != 16'hFFFF)) begin
            repeat_cnt_d = repeat_cnt_q + 16'd1;
        end else begin
            repeat_cnt_d = repeat_cnt_q;
        end
        if (resync_s && (resync_cnt_q != 16'hFFFF)) begin
            resync_cnt_d = resync_cnt_q + 16'd1;
        end else begin
            resync_cnt_d = resync_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            repeat_cnt_q <= 16'd0;
            resync_cnt_q <= 16'd0;
        end else begin
            repeat_cnt_q <= repeat_cnt_d;
            resync_cnt_q <= resync_cnt_d;
        end
    end

    assign repeat_cnt = repeat_cnt_q;
    assign resync_cnt = resync_cnt_q;
`else
    // Resync detection only feeds the statistics counters.
    logic unused_s;
    assign unused_s = resync_s;
`endif

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed testbench for fb_swap_ctrl with FRAME_PIXELS=16, ADDR_WIDTH=4.
module tb_fb_swap_ctrl;

    localparam int DW = 20;
    localparam int AW = 4;
    localparam int FP = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_sof;
    logic          s_ready;
    logic          vsync_pulse;
    logic [DW-1:0] wdata;
    logic [AW-1:0] waddr;
    logic          we;
    logic          selection;
    logic          swap_pulse;
    logic          frame_ready;
`ifdef FB_SWAP_STATS_EN
    logic [15:0]   repeat_cnt;
    logic [15:0]   resync_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fb_swap_ctrl #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .FRAME_PIXELS (FP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_sof       (s_sof),
        .s_ready     (s_ready),
        .vsync_pulse (vsync_pulse),
        .wdata       (wdata),
        .waddr       (waddr),
        .we          (we),
        .selection   (selection),
        .swap_pulse  (swap_pulse),
        .frame_ready (frame_ready)
`ifdef FB_SWAP_STATS_EN
        ,
        .repeat_cnt  (repeat_cnt),
        .resync_cnt  (resync_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted beat; checks the registered write produced by it.
    task automatic beat(input logic [DW-1:0] d, input logic sof, input int exp_addr, input string tag);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        tick();
        check_eq({tag, "_we"},    32'(we),    32'd1);
        check_eq({tag, "_waddr"}, 32'(waddr), 32'(exp_addr));
        check_eq({tag, "_wdata"}, 32'(wdata), 32'(d));
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic full_frame(input logic [DW-1:0] base, input string tag);
        for (int i = 0; i < FP; i++) begin
            beat(base + DW'(i), (i == 0), i, tag);
        end
        check_eq({tag, "_frame_ready"}, 32'(frame_ready), 32'd1);
        check_eq({tag, "_s_ready"},     32'(s_ready),     32'd0);
    endtask

    task automatic do_swap(input logic exp_sel, input string tag);
        vsync_pulse = 1'b1;
        tick();
        vsync_pulse = 1'b0;
        check_eq({tag, "_sel"},   32'(selection),  32'(exp_sel));
        check_eq({tag, "_swapp"}, 32'(swap_pulse), 32'd1);
        check_eq({tag, "_rdy"},   32'(s_ready),    32'd1);
        check_eq({tag, "_fr"},    32'(frame_ready), 32'd0);
        tick();
        check_eq({tag, "_swapp_end"}, 32'(swap_pulse), 32'd0);
    endtask

    int hits [FP];
    int frames;
    int cyc;
    int ok_cnt;
    logic sel_prev;

    initial begin
        rst         = 1'b1;
        s_data      = '0;
        s_valid     = 1'b0;
        s_sof       = 1'b0;
        vsync_pulse = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("rst_we",     32'(we),          32'd0);
        check_eq("rst_waddr",  32'(waddr),       32'd0);
        check_eq("rst_wdata",  32'(wdata),       32'd0);
        check_eq("rst_sel",    32'(selection),   32'd0);
        check_eq("rst_swapp",  32'(swap_pulse),  32'd0);
        check_eq("rst_fr",     32'(frame_ready), 32'd0);
        check_eq("rst_sready", 32'(s_ready),     32'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_sready", 32'(s_ready), 32'd1);

        // First frame, then stall with s_valid still high
        full_frame(20'h00100, "f1");
        check_eq("f1_sel", 32'(selection), 32'd0);
        s_valid = 1'b1;
        tick();
        check_eq("stall_we",    32'(we),    32'd0);
        check_eq("stall_waddr", 32'(waddr), 32'd15);
        s_valid = 1'b0;

        // Swap and second frame in the other bank
        do_swap(1'b1, "swap1");
        full_frame(20'h00200, "f2");
        check_eq("f2_sel", 32'(selection), 32'd1);
        do_swap(1'b0, "swap2");

        // vsync coinciding with the last accept is ignored
        for (int i = 0; i < FP - 1; i++) begin
            beat(20'h00300 + DW'(i), (i == 0), i, "f3");
        end
        vsync_pulse = 1'b1;
        beat(20'h0030F, 1'b0, 15, "f3_last");
        vsync_pulse = 1'b0;
        check_eq("f3_no_toggle", 32'(selection),   32'd0);
        check_eq("f3_no_swapp",  32'(swap_pulse),  32'd0);
        check_eq("f3_fr",        32'(frame_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        do_swap(1'b1, "swap3");
`ifdef FB_SWAP_STATS_EN
        check_eq("repeat_cnt", 32'(repeat_cnt), 32'd1);
`endif

        // Mid-frame start-of-frame resync
        for (int i = 0; i < 7; i++) begin
            beat(20'h00400 + DW'(i), (i == 0), i, "f4");
        end
        beat(20'h00ABC, 1'b1, 0, "resync");
        for (int i = 1; i < FP; i++) begin
            beat(20'h00500 + DW'(i), 1'b0, i, "f4b");
        end
        check_eq("f4_fr", 32'(frame_ready), 32'd1);
`ifdef FB_SWAP_STATS_EN
        check_eq("resync_cnt", 32'(resync_cnt), 32'd1);
`endif
        do_swap(1'b0, "swap4");
        full_frame(20'h00600, "f5");
        do_swap(1'b1, "swap5");

        // Reset in the middle of a frame
        for (int i = 0; i < 9; i++) begin
            beat(20'h00700 + DW'(i), (i == 0), i, "f6");
        end
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 20'h00709;
        tick();
        check_eq("mrst_we",    32'(we),        32'd0);
        check_eq("mrst_waddr", 32'(waddr),     32'd0);
        check_eq("mrst_sel",   32'(selection), 32'd0);
        rst     = 1'b0;
        s_valid = 1'b0;
        #1;
        check_eq("mrst_sready", 32'(s_ready), 32'd1);
        beat(20'h00800, 1'b0, 0, "after_rst");

        // Random valid gaps over three frames with periodic vsync
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < FP; i++) begin
            hits[i] = 0;
        end
        frames   = 0;
        cyc      = 0;
        sel_prev = selection;
        while (frames < 3 && cyc < 2000) begin
            s_valid     = ($urandom_range(0, 9) >= 3);
            s_data      = DW'($urandom);
            vsync_pulse = ((cyc % 40) == 39);
            tick();
            cyc++;
            if (selection !== sel_prev) begin
                check_eq("rand_swap_no_we", 32'(we), 32'd0);
            end
            sel_prev = selection;
            if (we) begin
                hits[waddr]++;
                if (waddr == AW'(FP - 1)) begin
                    ok_cnt = 0;
                    for (int i = 0; i < FP; i++) begin
                        if (hits[i] == 1) begin
                            ok_cnt++;
                        end
                        hits[i] = 0;
                    end
                    check_eq("rand_frame_cover", 32'(ok_cnt), 32'(FP));
                    frames++;
                end
            end
        end
        s_valid     = 1'b0;
        vsync_pulse = 1'b0;
        check_eq("rand_frames", 32'(frames), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_swap_ctrl.md
Name: fb_swap_ctrl

Overview:
- Write-side sequencer and buffer-swap controller for the double-buffered framebuffer (two 20-bit x 16K dpram banks plus a `selection` mux).
- Accepts a pixel stream from the renderer over a valid/ready handshake and generates `wdata`/`waddr`/`we` into the back buffer.
- Once a full frame has been written, it stalls the stream and toggles `selection` on the next display vsync, so the completed frame becomes the front buffer without tearing.
- Polarity: `selection`=1 → display reads bank 1, writes go to bank 2; `selection`=0 → the reverse.

Parameters:
- DATA_WIDTH, 20, pixel word width.
- ADDR_WIDTH, 14, framebuffer address width.
- FRAME_PIXELS, 16384, pixels per frame; legal range 2..2^ADDR_WIDTH.

Ports:
- clk  in  1  single clock for this block and the framebuffer write port.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_WIDTH  pixel from renderer.
- s_valid  in  1  s_data valid.
- s_sof  in  1  start-of-frame marker, qualified by s_valid.
- s_ready  out  1  block accepts a beat this cycle.
- vsync_pulse  in  1  one-cycle display frame boundary, already synchronised to clk.
- wdata  out  DATA_WIDTH  framebuffer write data.
- waddr  out  ADDR_WIDTH  framebuffer write address.
- we  out  1  framebuffer write enable.
- selection  out  1  framebuffer bank select.
- swap_pulse  out  1  one-cycle pulse in the cycle after selection toggles.
- frame_ready  out  1  back buffer complete, awaiting vsync.

Behaviour:
- Reset values (rst high at clk edge):
  - state=WRITE, wr_cnt=0, selection=0.
  - we=0, waddr=0, wdata=0, swap_pulse=0.
  - A partially written frame is discarded. Back buffer contents are undefined; nothing is cleared.
- Accept: `accept = s_valid & s_ready`. `s_ready` = (state==WRITE) & ~rst, combinational from state only.
- Write path: registered, latency 1. On accept: wdata<=s_data, waddr<=addr, we<=1. Otherwise we<=0, and waddr/wdata hold.
- Address rules:
  - addr = 0 if s_sof, else wr_cnt.
  - Next wr_cnt = addr+1, or 0 when addr==FRAME_PIXELS-1.
  - s_sof with wr_cnt!=0 is a resync: pixel goes to address 0, wr_cnt<=1, and the partial frame is abandoned.
  - s_sof with wr_cnt==0 is normal.
- State WRITE:
  - An accept with addr==FRAME_PIXELS-1 → WAIT_SWAP.
  - vsync_pulse is ignored here, including in the cycle of the last accept. The display repeats the current front frame.
- State WAIT_SWAP:
  - s_ready=0 and frame_ready=1.
  - On vsync_pulse: selection<=~selection, swap_pulse<=1 (registered, next cycle), state→WRITE, wr_cnt=0.
  - vsync_pulse in the first WAIT_SWAP cycle is honoured. The final pixel's we=1 and the selection toggle share the same edge, so the write still lands in the old back buffer.
- selection changes only on the WAIT_SWAP→WRITE transition; it never changes while we could be high for the current frame.
- FRAME_PIXELS==2^ADDR_WIDTH: the counter compare must not overflow; use an ADDR_WIDTH+1-bit compare or an explicit equality on FRAME_PIXELS-1.
- s_valid may drop mid-frame with no timeout; the block waits indefinitely.

Optional Feature:
- Macro: FB_SWAP_STATS_EN.
- Defined: adds ports `repeat_cnt` (out, 16) and `resync_cnt` (out, 16), both reset to 0 and saturating at 0xFFFF.
  - `repeat_cnt` increments on each vsync_pulse seen while state==WRITE.
  - `resync_cnt` increments on each resync accept.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan (FRAME_PIXELS=16, ADDR_WIDTH=4):
- Reset, then stream 16 beats data=0x100+i with s_valid held → we=1 at waddr 0..15 one cycle after each accept; frame_ready=1 after beat 15; s_ready=0; selection=0.
- From WAIT_SWAP, pulse vsync → selection=1 next cycle, swap_pulse=1 for exactly one cycle, s_ready=1; the next frame writes with selection=1.
- vsync in the same cycle as the 16th accept → no toggle. A second vsync 5 cycles later → selection toggles. With the macro defined, repeat_cnt=1.
- Stream 7 beats, then a beat with s_sof=1, data=0xABC → waddr=0 with wdata=0xABC, the following beat waddr=1, frame completes after 15 more beats; resync_cnt=1.
- Assert rst at beat 9 → we=0, waddr=0, s_ready=1 after reset; a new frame starts at waddr 0; selection returns to 0.
- Random s_valid gaps (30% idle) over 3 frames plus vsync every 40 cycles → every address 0..15 written exactly once per frame, and no we=1 coincides with a selection change.
